// File: rtl/k11_mem_pkg.sv
// Shared memory-access encodings used by the data-memory responder and by the
// execute-stage encoders that generate width_i.
package k11_mem_pkg;

  typedef enum logic [1:0] {
    WIDTH_BYTE    = 2'b00,
    WIDTH_HALF    = 2'b01,
    WIDTH_WORD    = 2'b10,
    WIDTH_ILLEGAL = 2'b11
  } mem_width_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } resp_state_e;

  localparam int LANES = 4;

endpackage

// File: rtl/dmem_bank.sv
// Word-organised data storage: one byte-wide array per lane, independent lane
// write enables and a registered read that only advances when rd_en_i is high.
module dmem_bank
  import k11_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic [AW-1:0]    addr_i,
  input  logic             rd_en_i,
  input  logic [LANES-1:0] we_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_ro
);

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] r_mem [DEPTH_WORDS];
      logic [7:0] r_rd;

      always_ff @(posedge clk) begin
        if (we_i[gi]) r_mem[addr_i] <= wdata_i[8*gi +: 8];
        if (rd_en_i)  r_rd <= r_mem[addr_i];
      end

      assign rdata_ro[8*gi +: 8] = r_rd;
    end
  endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Single-entry load/store responder in front of dmem_bank: alignment and range
// checks, byte-lane steering for stores, extraction and extension for loads.
module dmem_responder
  import k11_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ERRCNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [31:0]         addr_i,
  input  logic [1:0]          width_i,
  input  logic                write_i,
  input  logic                unsigned_i,
  input  logic [31:0]         wdata_i,
  output logic                valid_ro,
  input  logic                ready_i,
  output logic [31:0]         rdata_ro,
  output logic                err_ro,
  output logic [ERRCNT_W-1:0] errcnt_ro
);

  localparam int AW = $clog2(DEPTH_WORDS);

  resp_state_e         r_state, w_state_next;
  logic                r_is_load, r_err, r_unsigned;
  logic [1:0]          r_off;
  mem_width_e          r_width;
  logic [ERRCNT_W-1:0] r_errcnt;

  mem_width_e          w_width;
  logic                w_accept, w_consume, w_misalign, w_oob, w_err;
  logic [LANES-1:0]    w_lane_en, w_we;
  logic [31:0]         w_wdata, w_raw, w_load_ext;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;

  assign w_width   = mem_width_e'(width_i);
  assign ready_o   = (r_state == ST_EMPTY) || ready_i;
  assign w_accept  = valid_i && ready_o && !rst;
  assign w_consume = (r_state == ST_FULL) && ready_i;

  always_comb begin
    w_misalign = 1'b0;
    w_lane_en  = 4'b0000;
    w_wdata    = wdata_i;
    case (w_width)
      WIDTH_BYTE: begin
        w_lane_en = 4'b0001 << addr_i[1:0];
        w_wdata   = {4{wdata_i[7:0]}};
      end
      WIDTH_HALF: begin
        w_misalign = addr_i[0];
        w_lane_en  = addr_i[1] ? 4'b1100 : 4'b0011;
        w_wdata    = {2{wdata_i[15:0]}};
      end
      WIDTH_WORD: begin
        w_misalign = |addr_i[1:0];
        w_lane_en  = 4'b1111;
      end
      default: w_misalign = 1'b1;
    endcase
  end

  assign w_oob = ({2'b00, addr_i[31:2]} >= 32'(DEPTH_WORDS));
  assign w_err = w_misalign || w_oob;
  assign w_we  = (w_accept && write_i && !w_err) ? w_lane_en : 4'b0000;

  dmem_bank #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_bank (
    .clk      (clk),
    .addr_i   (addr_i[AW+1:2]),
    .rd_en_i  (w_accept && !write_i && !w_err),
    .we_i     (w_we),
    .wdata_i  (w_wdata),
    .rdata_ro (w_raw)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept) w_state_next = ST_FULL;
      ST_FULL: begin
        if (w_accept)     w_state_next = ST_FULL;
        else if (ready_i) w_state_next = ST_EMPTY;
      end
      default: w_state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_EMPTY;
    else     r_state <= w_state_next;
  end

  // The bank's read register doubles as the response data register; the
  // captured lane offset/width select from it so the whole response holds
  // while stalled without a second 32-bit copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_is_load <= 1'b0;
      r_err     <= 1'b0;
      r_errcnt  <= '0;
    end else if (w_accept) begin
      r_is_load  <= !write_i && !w_err;
      r_err      <= w_err;
      r_off      <= addr_i[1:0];
      r_width    <= w_width;
      r_unsigned <= unsigned_i;
      if (w_err && !(&r_errcnt)) r_errcnt <= r_errcnt + ERRCNT_W'(1);
    end else if (w_consume) begin
      r_is_load <= 1'b0;
      r_err     <= 1'b0;
    end
  end

  assign w_byte = w_raw[{r_off, 3'b000} +: 8];
  assign w_half = r_off[1] ? w_raw[31:16] : w_raw[15:0];

  always_comb begin
    w_load_ext = w_raw;
    case (r_width)
      WIDTH_BYTE: w_load_ext = {{24{!r_unsigned && w_byte[7]}}, w_byte};
      WIDTH_HALF: w_load_ext = {{16{!r_unsigned && w_half[15]}}, w_half};
      default:    w_load_ext = w_raw;
    endcase
  end

  assign valid_ro  = (r_state == ST_FULL);
  assign rdata_ro  = r_is_load ? w_load_ext : 32'h0;
  assign err_ro    = r_err;
  assign errcnt_ro = r_errcnt;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed literal scenarios followed
// by randomized traffic compared every cycle against a byte-array memory model.
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int ECW   = 8;
  localparam int ECMAX = (1 << ECW) - 1;

  logic           clk;
  logic           rst;
  logic           valid_i;
  logic           ready_o;
  logic [31:0]    addr_i;
  logic [1:0]     width_i;
  logic           write_i;
  logic           unsigned_i;
  logic [31:0]    wdata_i;
  logic           valid_ro;
  logic           ready_i;
  logic [31:0]    rdata_ro;
  logic           err_ro;
  logic [ECW-1:0] errcnt_ro;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .ERRCNT_W    (ECW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .addr_i     (addr_i),
    .width_i    (width_i),
    .write_i    (write_i),
    .unsigned_i (unsigned_i),
    .wdata_i    (wdata_i),
    .valid_ro   (valid_ro),
    .ready_i    (ready_i),
    .rdata_ro   (rdata_ro),
    .err_ro     (err_ro),
    .errcnt_ro  (errcnt_ro)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [7:0]    mem_m [DEPTH*4];
  logic        ev;
  logic [31:0] erd;
  logic        ee;
  int          ecnt;

  function automatic logic req_bad(input logic [31:0] a, input logic [1:0] w);
    if (w == 2'd3) return 1'b1;
    if (w == 2'd1 && a[0]) return 1'b1;
    if (w == 2'd2 && a[1:0] != 2'd0) return 1'b1;
    if ((a >> 2) >= DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    logic        acc;
    int          nb;
    int          base;
    logic [31:0] v;
    ev = 1'b0; erd = '0; ee = 1'b0; ecnt = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        ev = 1'b0; erd = '0; ee = 1'b0; ecnt = 0;
      end else begin
        acc = valid_i && (!ev || ready_i);
        if (acc) begin
          ev = 1'b1;
          if (req_bad(addr_i, width_i)) begin
            ee = 1'b1; erd = '0;
            if (ecnt < ECMAX) ecnt++;
          end else begin
            ee   = 1'b0;
            nb   = 1 << width_i;
            base = int'(addr_i);
            if (write_i) begin
              for (int k = 0; k < nb; k++) mem_m[base+k] = wdata_i[8*k +: 8];
              erd = '0;
            end else begin
              v = '0;
              for (int k = 0; k < nb; k++) v = v | (32'(mem_m[base+k]) << (8*k));
              if (!unsigned_i && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
              erd = v;
            end
          end
        end else if (ev && ready_i) begin
          ev = 1'b0;
        end
      end
      @(negedge clk);
      check("valid_ro", valid_ro, ev);
      check("ready_o", ready_o, !ev || ready_i);
      check("errcnt_ro", errcnt_ro, ecnt);
      if (ev) begin
        check("rdata_ro", rdata_ro, erd);
        check("err_ro", err_ro, ee);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input logic [31:0] a, input logic [1:0] w,
                       input logic wr, input logic u, input logic [31:0] d);
    valid_i = v; addr_i = a; width_i = w; write_i = wr; unsigned_i = u; wdata_i = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] a, input logic [1:0] w, input logic wr,
                     input logic u, input logic [31:0] d);
    drive(1'b1, a, w, wr, u, d);
    step();
    $display("txn wr=%0d w=%0d a=%h d=%h -> valid=%0d rdata=%h err=%0d errcnt=%0d",
             wr, w, a, d, valid_ro, rdata_ro, err_ro, errcnt_ro);
    drive(1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; ready_i = 1'b1;
    drive(1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0);
    repeat (3) step();
    check("reset valid_ro", valid_ro, 1'b0);
    check("reset errcnt_ro", errcnt_ro, 0);
    check("reset ready_o", ready_o, 1'b1);
    rst = 1'b0;

    // Fill storage so every later load has a known answer.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 32'(i*4), 2'd2, 1'b1, 1'b0, 32'(i) * 32'h0101_0101 ^ 32'hC3C3_C3C3);
      step();
    end
    drive(1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0);
    step();

    req(32'h10, 2'd2, 1'b1, 1'b0, 32'hDEAD_BEEF);
    check("store rdata 0", rdata_ro, 32'h0);
    req(32'h10, 2'd2, 1'b0, 1'b0, 32'h0);
    check("lw 0x10", rdata_ro, 32'hDEAD_BEEF);
    check("lw 0x10 err", err_ro, 1'b0);
    req(32'h13, 2'd0, 1'b0, 1'b0, 32'h0);
    check("lb 0x13", rdata_ro, 32'hFFFF_FFDE);
    req(32'h13, 2'd0, 1'b0, 1'b1, 32'h0);
    check("lbu 0x13", rdata_ro, 32'h0000_00DE);
    req(32'h12, 2'd1, 1'b0, 1'b0, 32'h0);
    check("lh 0x12", rdata_ro, 32'hFFFF_DEAD);
    req(32'h11, 2'd0, 1'b1, 1'b0, 32'h0000_0055);
    req(32'h10, 2'd2, 1'b0, 1'b0, 32'h0);
    check("lw after sb", rdata_ro, 32'hDEAD_55EF);
    req(32'h12, 2'd2, 1'b0, 1'b0, 32'h0);
    check("misaligned err", err_ro, 1'b1);
    check("misaligned rdata", rdata_ro, 32'h0);
    check("misaligned errcnt", errcnt_ro, 1);
    req(32'h12, 2'd2, 1'b1, 1'b0, 32'hFFFF_FFFF);
    req(32'h10, 2'd2, 1'b0, 1'b0, 32'h0);
    check("mem unchanged", rdata_ro, 32'hDEAD_55EF);
    req(32'h14, 2'd2, 1'b1, 1'b0, 32'h1234_5678);

    // Stall with a load pending, then release with a new request waiting.
    req(32'h14, 2'd2, 1'b0, 1'b0, 32'h0);
    ready_i = 1'b0;
    drive(1'b1, 32'h10, 2'd2, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall ready_o", ready_o, 1'b0);
      check("stall valid_ro", valid_ro, 1'b1);
      check("stall rdata", rdata_ro, 32'h1234_5678);
    end
    ready_i = 1'b1;
    step();
    check("b2b valid_ro", valid_ro, 1'b1);
    check("b2b rdata", rdata_ro, 32'hDEAD_55EF);
    drive(1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0);
    step();
    check("drain valid_ro", valid_ro, 1'b0);

    drive(1'b1, 32'h0, 2'd3, 1'b0, 1'b0, 32'h0);
    repeat (300) step();
    check("errcnt sat", errcnt_ro, ECMAX);
    check("illegal err", err_ro, 1'b1);

    // Reset with a pending response and a store presented in the reset cycle.
    rst = 1'b1;
    drive(1'b1, 32'h10, 2'd2, 1'b1, 1'b0, 32'h0000_0000);
    step();
    check("rst valid_ro", valid_ro, 1'b0);
    check("rst errcnt", errcnt_ro, 0);
    rst = 1'b0;
    drive(1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0);
    req(32'h10, 2'd2, 1'b0, 1'b0, 32'h0);
    check("survives rst 0x10", rdata_ro, 32'hDEAD_55EF);
    req(32'h14, 2'd2, 1'b0, 1'b0, 32'h0);
    check("survives rst 0x14", rdata_ro, 32'h1234_5678);

    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 199) == 0);
      valid_i    = ($urandom_range(0, 3) != 0);
      ready_i    = ($urandom_range(0, 3) != 0);
      addr_i     = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, DEPTH*4 + 7));
      width_i    = 2'($urandom_range(0, 3));
      write_i    = 1'($urandom_range(0, 1));
      unsigned_i = 1'($urandom_range(0, 1));
      wdata_i    = $urandom;
      step();
    end
    rst = 1'b0; ready_i = 1'b1;
    drive(1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0);
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words stored (power of two).
REQ-002 SHALL have parameter ERRCNT_W, default 8, width of the error counter.
REQ-003 SHALL have port clk  in  1  the only clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port valid_i  in  1  request valid.
REQ-006 SHALL have port ready_o  out  1  request ready.
REQ-007 SHALL have port addr_i  in  32  byte address.
REQ-008 SHALL have port width_i  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-009 SHALL have port write_i  in  1  1 store, 0 load.
REQ-010 SHALL have port unsigned_i  in  1  load zero-extends when 1, sign-extends when 0.
REQ-011 SHALL have port wdata_i  in  32  store data, right-justified.
REQ-012 SHALL have port valid_ro  out  1  response valid (registered).
REQ-013 SHALL have port ready_i  in  1  response consumer ready.
REQ-014 SHALL have port rdata_ro  out  32  load result (registered), 0 for stores and errors.
REQ-015 SHALL have port err_ro  out  1  response is an error (registered).
REQ-016 SHALL have port errcnt_ro  out  ERRCNT_W  saturating count of error responses.

Function
REQ-017 Request SHALL be accepted on a cycle with valid_i && ready_o.
REQ-018 ready_o SHALL equal !valid_ro || ready_i (combinational, single-entry output register).
REQ-019 Response SHALL be consumed on a cycle with valid_ro && ready_i.
REQ-020 Two-state FSM: EMPTY (valid_ro=0) / FULL (valid_ro=1); EMPTY->FULL on accept; FULL->EMPTY on consume without accept; FULL->FULL on consume with accept (new response loaded, no bubble).
REQ-021 Latency SHALL be exactly 1 cycle: response registered on the edge that accepts the request.
REQ-022 While FULL and ready_i=0, valid_ro, rdata_ro, err_ro SHALL hold stable.
REQ-023 Error SHALL be flagged when width_i=11, half with addr_i[0]=1, word with addr_i[1:0]!=00, or addr_i[31:2] >= DEPTH_WORDS.
REQ-024 Erroring requests SHALL not modify storage and SHALL return rdata_ro=0, err_ro=1.
REQ-025 Store byte lanes: byte -> lane addr_i[1:0] from wdata_i[7:0]; half -> lanes addr_i[1]*2 +{0,1} from wdata_i[15:0]; word -> all lanes; little-endian.
REQ-026 Store response SHALL be rdata_ro=0, err_ro=0; write committed on the accepting edge.
REQ-027 Load SHALL select the addressed byte/half, right-justify it, and sign- or zero-extend to 32 bits per unsigned_i.
REQ-028 Load accepted the cycle after a store to the same word SHALL return the stored data.
REQ-029 errcnt_ro SHALL increment on each accepted erroring request and saturate at all-ones.
REQ-030 Inputs other than valid_i SHALL be ignored when no request is accepted.

Reset
REQ-031 During rst: valid_ro=0, rdata_ro=0, err_ro=0, errcnt_ro=0, FSM=EMPTY; ready_o therefore 1 once rst deasserts.
REQ-032 rst asserted mid-transaction SHALL drop any held response; a request presented in the rst cycle SHALL not be accepted and SHALL not write.
REQ-033 Storage contents SHALL not be cleared by rst.

Structure
REQ-034 Width encodings (BYTE/HALF/WORD/ILLEGAL) SHALL live in shared package k11_mem_pkg, also used by execute-stage encoders.
REQ-035 Storage SHALL be sub-module dmem_bank: DEPTH_WORDS x 4 byte lanes, synchronous read, per-lane write enable.
REQ-036 Lane-enable, alignment check and load extension SHALL be in dmem_responder.

Verification
REQ-037 Store word 0xDEADBEEF at 0x10, then load word 0x10 -> rdata_ro=0xDEADBEEF, err_ro=0, 1 cycle after accept.
REQ-038 After REQ-037: load byte 0x13 signed -> 0xFFFFFFDE; unsigned -> 0x000000DE; load half 0x12 signed -> 0xFFFFDEAD.
REQ-039 Store byte 0x55 at 0x11 then load word 0x10 -> 0xDEAD55EF; load word 0x12 -> err_ro=1, rdata_ro=0, errcnt_ro=1, memory unchanged.
REQ-040 Hold ready_i=0 for 3 cycles with a load pending -> ready_o=0, outputs stable; release with valid_i high -> back-to-back responses, no bubble.
REQ-041 Width 11 request 300 times (ERRCNT_W=8) -> errcnt_ro=255; then rst -> valid_ro=0, errcnt_ro=0, prior stored data still readable.
